mdio_slave: RTL and testbench
=============================

Name: mdio_slave

Overview:
- Clause 22 MDIO management responder, the PHY-side counterpart of the phy_mdio initiator.
- Oversamples MDC/MDIO in the system clock domain and decodes read and write frames.
- Serves a local 32x16 register file that a host port can also access.
- Used as a PHY register model in loopback benches, and as the management endpoint of slave-node FPGA builds.

Parameters:
- PHY_ADDR, 5'd0, PHYAD value the block answers to.
- PREAMBLE, 1: 1 = 32 consecutive ones required before ST; 0 = preamble suppression (any 0 seen in IDLE starts ST).
- SYNC_STAGES, 2: synchronizer depth on mdc and mdio_i, minimum 2.

Ports:
- clk  in  1  system clock; must be at least 8x MDC.
- rst  in  1  synchronous, active-high reset.
- mdc  in  1  management clock from the initiator (asynchronous).
- mdio_i  in  1  MDIO line input (asynchronous).
- mdio_o  out  1  MDIO drive value.
- mdio_oe  out  1  MDIO output enable; top level builds the tristate.
- h_ra  in  5  host register address.
- h_wd  in  16  host write data.
- h_we  in  1  host write strobe.
- h_rd  out  16  host read data, registered: reg[h_ra] one clk later.
- wr_ra  out  5  address of the last MDIO write.
- wr_d  out  16  data of the last MDIO write.
- wr_dv  out  1  1-clk pulse when an MDIO write commits.
- rd_dv  out  1  1-clk pulse when an MDIO read frame completes.
- frame_err  out  1  1-clk pulse on a malformed frame.
- mdint  out  1  interrupt; present only with the optional feature.

Behaviour:
- Reset values: all outputs 0, register file all zeros, state IDLE, preamble count 0.
- Input sampling:
  - mdc and mdio_i each pass through SYNC_STAGES flops with equal depth.
  - An MDC rising edge is "sync mdc 1, previous 0". All sampling and drive updates happen on the clk of that detection ("rise").
- States: IDLE, ST, OP, PHYAD, REGAD, TA, DATA.
- IDLE:
  - Each rise with mdio=1 increments the preamble count, saturating at 32. A rise with mdio=0 clears the count.
  - That same 0 rise enters ST if the count was 32 (or if PREAMBLE=0).
- ST: the next bit must be 1; otherwise frame_err and return to IDLE.
- OP: 2 bits. 10 = read, 01 = write, 00/11 = frame_err and IDLE.
- PHYAD: 5 bits, MSB first. On mismatch with PHY_ADDR, the rest of the frame is ignored silently: no drive, no error, IDLE.
- REGAD: 5 bits. On the last REGAD rise, reg[REGAD] is snapshotted into a 16-bit shift register. Later host writes do not affect an in-flight read.
- TA, read:
  - On the rise sampling TA bit 1, set mdio_oe=1 and mdio_o=0.
  - On the TA bit 2 rise, drive D15.
  - Each subsequent rise shifts out the next bit, MSB first.
  - On the rise of the D0 period, drop mdio_oe, pulse rd_dv, go to IDLE.
- TA, write:
  - The sampled TA bits must be 10; otherwise frame_err and the frame is discarded.
  - Capture 16 data bits MSB first.
  - On the 16th rise, write the register file and set wr_ra/wr_d.
  - Pulse wr_dv on the same clk; go to IDLE.
- mdio_oe is 1 only during the TA2 and D15..D0 periods of an addressed read.
- Host port:
  - h_we writes reg[h_ra] at the clk edge.
  - If an MDIO write commits in the same clk to the same address, the MDIO write wins.
  - A read on h_rd of an address written in the same clk returns the old value.
- After any frame end or error, a new frame requires a fresh preamble (PREAMBLE=1).
- rst mid-frame: mdio_oe=0 immediately on the next clk, state IDLE, no wr_dv. The register file is cleared.

Optional Feature:
- Macro MDIO_SLAVE_INT_EN.
- Defined:
  - mdint port exists, reset 0.
  - mdint goes to 1 on any committed MDIO write to a register other than 5'h1A.
  - mdint clears on completion of an MDIO read of register 5'h1A (status-read-clears).
  - Set and clear in the same clk: set wins.
- Undefined: mdint port and logic are absent; all other behaviour is identical.

Test Plan:
- Write, then read back: PREAMBLE=1, PHY_ADDR=1.
  - Write frame to PHYAD 1, REGAD 0x04, data 0xA5C3 -> wr_dv pulse, wr_ra=0x04, wr_d=0xA5C3.
  - Then h_ra=0x04 -> h_rd=0xA5C3.
- MDIO read of a host-written register: host writes reg 0x02=0x1234, then an MDIO read of 0x02 -> mdio_oe rises at TA2 with mdio_o=0, then serial bits 0001001000110100, rd_dv pulse, mdio_oe=0 after D0.
- PHYAD mismatch: read frame to PHYAD 3 -> mdio_oe stays 0; no rd_dv, wr_dv or frame_err.
- Malformed frames:
  - OP=11 -> frame_err pulse.
  - Write with TA=11 -> frame_err, reg unchanged.
  - Only 31 preamble ones -> frame ignored.
- Collisions:
  - Host writes 0x0004 into reg 0x04 during a read of 0x04 (preloaded 0xFFFF) -> serial data 0xFFFF.
  - Host and MDIO write to 0x07 in the same clk -> MDIO value stored.
- Reset and interrupt:
  - rst asserted at D8 of a read -> mdio_oe=0 on the next clk. A following well-formed frame is decoded correctly.
  - With MDIO_SLAVE_INT_EN: write to 0x10 -> mdint=1; read of 0x1A -> mdint=0.

Source files
------------

// File: rtl/mdio_slave.sv
// Clause 22 MDIO responder: oversamples MDC/MDIO, decodes read/write frames and
// serves a 32x16 register file shared with a host port. MDIO_SLAVE_INT_EN adds mdint.
module mdio_slave #(
    parameter logic [4:0] PHY_ADDR    = 5'd0,
    parameter int         PREAMBLE    = 1,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic [4:0]  h_ra,
    input  logic [15:0] h_wd,
    input  logic        h_we,
    output logic [15:0] h_rd,
    output logic [4:0]  wr_ra,
    output logic [15:0] wr_d,
    output logic        wr_dv,
    output logic        rd_dv,
    output logic        frame_err
`ifdef MDIO_SLAVE_INT_EN
    ,
    output logic        mdint
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA
    } state_t;

    localparam logic [5:0] PRE_FULL       = 6'd32;
    localparam logic [4:0] INT_STATUS_REG = 5'h1A;

    logic [SYNC_STAGES-1:0] mdc_sync;
    logic [SYNC_STAGES-1:0] mdio_sync;
    logic                   mdc_prev;
    logic                   rise;
    logic                   bit_in;

    state_t      state;
    logic [5:0]  pre_cnt;
    logic [3:0]  bit_cnt;
    logic        is_read;
    logic [4:0]  addr_sr;
    logic [4:0]  addr_next;
    logic [4:0]  reg_addr;
    logic [15:0] shift_q;

    logic [15:0] regs [32];
    logic        commit;
    logic [15:0] commit_data;

    // Both inputs see the same depth so a data bit stays aligned with its clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdc_sync  <= '0;
            mdio_sync <= '0;
            mdc_prev  <= 1'b0;
        end else begin
            mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc};
            mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_i};
            mdc_prev  <= mdc_sync[SYNC_STAGES-1];
        end
    end

    assign rise        = mdc_sync[SYNC_STAGES-1] & ~mdc_prev;
    assign bit_in      = mdio_sync[SYNC_STAGES-1];
    assign addr_next   = {addr_sr[3:0], bit_in};
    assign commit      = rise && (state == S_DATA) && !is_read && (bit_cnt == 4'd15);
    assign commit_data = {shift_q[14:0], bit_in};

    // Host port: h_we is a plain write strobe; a same-clk MDIO commit lands last and wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            h_rd <= '0;
        end else begin
            h_rd <= regs[h_ra];
            if (h_we) begin
                regs[h_ra] <= h_wd;
            end
            if (commit) begin
                regs[reg_addr] <= commit_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pre_cnt   <= '0;
            bit_cnt   <= '0;
            is_read   <= 1'b0;
            addr_sr   <= '0;
            reg_addr  <= '0;
            shift_q   <= '0;
            mdio_o    <= 1'b0;
            mdio_oe   <= 1'b0;
            wr_ra     <= '0;
            wr_d      <= '0;
            wr_dv     <= 1'b0;
            rd_dv     <= 1'b0;
            frame_err <= 1'b0;
`ifdef MDIO_SLAVE_INT_EN
            mdint     <= 1'b0;
`endif
        end else begin
            wr_dv     <= 1'b0;
            rd_dv     <= 1'b0;
            frame_err <= 1'b0;
            if (rise) begin
                case (state)
                    S_IDLE: begin
                        if (bit_in) begin
                            if (pre_cnt != PRE_FULL) begin
                                pre_cnt <= pre_cnt + 6'd1;
                            end
                        end else begin
                            pre_cnt <= '0;
                            if ((pre_cnt == PRE_FULL) || (PREAMBLE == 0)) begin
                                state <= S_ST;
                            end
                        end
                    end
                    S_ST: begin
                        bit_cnt <= '0;
                        if (bit_in) begin
                            state <= S_OP;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                    S_OP: begin
                        addr_sr <= addr_next;
                        if (bit_cnt == 4'd0) begin
                            bit_cnt <= 4'd1;
                        end else if (addr_next[1:0] == 2'b10 || addr_next[1:0] == 2'b01) begin
                            is_read <= addr_next[1];
                            bit_cnt <= '0;
                            state   <= S_PHYAD;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                    S_PHYAD: begin
                        addr_sr <= addr_next;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd4) begin
                            bit_cnt <= '0;
                            // Another PHY's frame: drop out quietly and wait for a new preamble.
                            state   <= (addr_next == PHY_ADDR) ? S_REGAD : S_IDLE;
                        end
                    end
                    S_REGAD: begin
                        addr_sr <= addr_next;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd4) begin
                            bit_cnt  <= '0;
                            reg_addr <= addr_next;
                            state    <= S_TA;
                            if (is_read) begin
                                shift_q <= regs[addr_next];
                            end
                        end
                    end
                    S_TA: begin
                        addr_sr <= addr_next;
                        if (bit_cnt == 4'd0) begin
                            bit_cnt <= 4'd1;
                            if (is_read) begin
                                mdio_oe <= 1'b1;
                                mdio_o  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= '0;
                            if (is_read) begin
                                mdio_o  <= shift_q[15];
                                shift_q <= {shift_q[14:0], 1'b0};
                                state   <= S_DATA;
                            end else if (addr_next[1:0] == 2'b10) begin
                                state <= S_DATA;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_IDLE;
                            end
                        end
                    end
                    S_DATA: begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (is_read) begin
                            if (bit_cnt == 4'd15) begin
                                mdio_oe <= 1'b0;
                                mdio_o  <= 1'b0;
                                rd_dv   <= 1'b1;
                                state   <= S_IDLE;
`ifdef MDIO_SLAVE_INT_EN
                                if (reg_addr == INT_STATUS_REG) begin
                                    mdint <= 1'b0;
                                end
`endif
                            end else begin
                                mdio_o  <= shift_q[15];
                                shift_q <= {shift_q[14:0], 1'b0};
                            end
                        end else begin
                            shift_q <= commit_data;
                            if (bit_cnt == 4'd15) begin
                                wr_ra <= reg_addr;
                                wr_d  <= commit_data;
                                wr_dv <= 1'b1;
                                state <= S_IDLE;
`ifdef MDIO_SLAVE_INT_EN
                                if (reg_addr != INT_STATUS_REG) begin
                                    mdint <= 1'b1;
                                end
`endif
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdio_slave.sv
// Bench for mdio_slave: directed and random MDIO frames checked against a
// register-file model of the frame rules; host port checked through h_rd.
module tb_mdio_slave;

    localparam logic [4:0] PHY     = 5'd1;
    localparam int         SYNC    = 2;
    localparam int         HALF    = 8;
    localparam logic [4:0] INT_REG = 5'h1A;

    logic        clk = 1'b0;
    logic        rst;
    logic        mdc;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_oe;
    logic [4:0]  h_ra;
    logic [15:0] h_wd;
    logic        h_we;
    logic [15:0] h_rd;
    logic [4:0]  wr_ra;
    logic [15:0] wr_d;
    logic        wr_dv;
    logic        rd_dv;
    logic        frame_err;
`ifdef MDIO_SLAVE_INT_EN
    logic        mdint;
`endif

    mdio_slave #(
        .PHY_ADDR   (PHY),
        .PREAMBLE   (1),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mdc      (mdc),
        .mdio_i   (mdio_i),
        .mdio_o   (mdio_o),
        .mdio_oe  (mdio_oe),
        .h_ra     (h_ra),
        .h_wd     (h_wd),
        .h_we     (h_we),
        .h_rd     (h_rd),
        .wr_ra    (wr_ra),
        .wr_d     (wr_d),
        .wr_dv    (wr_dv),
        .rd_dv    (rd_dv),
        .frame_err(frame_err)
`ifdef MDIO_SLAVE_INT_EN
        ,
        .mdint    (mdint)
`endif
    );

    always #5 clk = ~clk;

    // Reference model and scoreboard state
    logic [15:0] model_regs [32];
    bit          model_int = 1'b0;
    logic [15:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    int          wr_pulses = 0;
    int          rd_pulses = 0;
    int          err_pulses = 0;
    logic [4:0]  seen_wr_ra = '0;
    logic [15:0] seen_wr_d = '0;

    always @(negedge clk) begin
        if (wr_dv === 1'b1) begin
            wr_pulses++;
            seen_wr_ra = wr_ra;
            seen_wr_d  = wr_d;
        end
        if (rd_dv === 1'b1) rd_pulses++;
        if (frame_err === 1'b1) err_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic host_write(input logic [4:0] a, input logic [15:0] v);
        h_ra = a;
        h_wd = v;
        h_we = 1'b1;
        @(negedge clk);
        h_we = 1'b0;
        model_regs[a] = v;
    endtask

    task automatic host_check(input logic [4:0] a);
        h_ra = a;
        @(negedge clk);
        check_eq("h_rd", 32'(h_rd), 32'(model_regs[a]));
    endtask

    // One MDC period; returns what an initiator would sample at this rising edge.
    // host_sync lands a host write on the clk where the slave acts on this edge.
    task automatic send_bit(input logic b, input bit host_sync, input logic [4:0] ha,
                            input logic [15:0] hv, output logic s_oe, output logic s_o);
        mdio_i = b;
        repeat (HALF) @(negedge clk);
        s_oe = mdio_oe;
        s_o  = mdio_o;
        mdc  = 1'b1;
        if (host_sync) begin
            repeat (SYNC) @(negedge clk);
            h_ra = ha;
            h_wd = hv;
            h_we = 1'b1;
            @(negedge clk);
            h_we = 1'b0;
            repeat (HALF - SYNC - 1) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        mdc = 1'b0;
    endtask

    // mode 0: plain, 1: host write of hv after REGAD, 2: host write of hv on the commit clk
    task automatic run_frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] ra, input logic [15:0] wd, input logic [1:0] ta,
                             input int mode, input logic [15:0] hv);
        logic        s_oe, s_o, ta2_oe, ta2_o;
        logic [13:0] hdr;
        logic [17:0] tx;
        logic [15:0] word;
        int          oe_hi, wr0, rd0, er0;
        bit          is_rd, live, do_rd, do_wr, do_err;
        wr0    = wr_pulses;
        rd0    = rd_pulses;
        er0    = err_pulses;
        oe_hi  = 0;
        word   = '0;
        ta2_oe = 1'b0;
        ta2_o  = 1'b0;
        is_rd  = (op == 2'b10);
        live   = (pre_len >= 32);
        do_err = live && (op == 2'b00 || op == 2'b11);
        live   = live && !do_err && (phy == PHY);
        do_rd  = live && is_rd;
        do_wr  = live && !is_rd && (ta == 2'b10);
        do_err = do_err || (live && !is_rd && (ta != 2'b10));

        send_bit(1'b0, 1'b0, ra, hv, s_oe, s_o);
        if (s_oe) oe_hi++;
        for (int i = 0; i < pre_len; i++) begin
            send_bit(1'b1, 1'b0, ra, hv, s_oe, s_o);
            if (s_oe) oe_hi++;
        end
        hdr = {2'b01, op, phy, ra};
        for (int i = 0; i < 14; i++) begin
            send_bit(hdr[13], 1'b0, ra, hv, s_oe, s_o);
            hdr = {hdr[12:0], 1'b0};
            if (s_oe) oe_hi++;
        end
        if (do_rd) exp_q.push_back(model_regs[ra]);
        if (mode == 1) host_write(ra, hv);
        if (mode == 2) model_regs[ra] = hv;
        tx = is_rd ? '1 : {ta, wd};
        for (int i = 0; i < 18; i++) begin
            send_bit(tx[17], (mode == 2) && (i == 17), ra, hv, s_oe, s_o);
            tx = {tx[16:0], 1'b0};
            if (s_oe) oe_hi++;
            if (i == 1) begin
                ta2_oe = s_oe;
                ta2_o  = s_o;
            end
            if (i >= 2) word = {word[14:0], s_o};
        end

        check_eq("oe_cycles", 32'(oe_hi), do_rd ? 32'd17 : 32'd0);
        check_eq("wr_dv", 32'(wr_pulses - wr0), 32'(do_wr));
        check_eq("rd_dv", 32'(rd_pulses - rd0), 32'(do_rd));
        check_eq("frame_err", 32'(err_pulses - er0), 32'(do_err));
        if (do_rd) begin
            check_eq("ta2_oe", 32'(ta2_oe), 32'd1);
            check_eq("ta2_o", 32'(ta2_o), 32'd0);
            check_eq("rd_data", 32'(word), 32'(exp_q.pop_front()));
            check_eq("oe_after", 32'(mdio_oe), 32'd0);
            if (ra == INT_REG) model_int = 1'b0;
        end
        if (do_wr) begin
            model_regs[ra] = wd;
            if (ra != INT_REG) model_int = 1'b1;
            check_eq("wr_ra", 32'(seen_wr_ra), 32'(ra));
            check_eq("wr_d", 32'(seen_wr_d), 32'(wd));
        end
`ifdef MDIO_SLAVE_INT_EN
        check_eq("mdint", 32'(mdint), 32'(model_int));
`endif
    endtask

    task automatic read_with_reset(input logic [4:0] ra);
        logic        s_oe, s_o;
        logic [13:0] hdr;
        logic [15:0] word;
        int          wr0, rd0;
        wr0  = wr_pulses;
        rd0  = rd_pulses;
        word = '0;
        send_bit(1'b0, 1'b0, ra, 16'h0, s_oe, s_o);
        for (int i = 0; i < 32; i++) send_bit(1'b1, 1'b0, ra, 16'h0, s_oe, s_o);
        hdr = {2'b01, 2'b10, PHY, ra};
        for (int i = 0; i < 14; i++) begin
            send_bit(hdr[13], 1'b0, ra, 16'h0, s_oe, s_o);
            hdr = {hdr[12:0], 1'b0};
        end
        for (int i = 0; i < 10; i++) begin
            send_bit(1'b1, 1'b0, ra, 16'h0, s_oe, s_o);
            if (i >= 2) word = {word[14:0], s_o};
        end
        check_eq("rst_pre_oe", 32'(mdio_oe), 32'd1);
        check_eq("rst_partial", 32'(word[7:0]), 32'(model_regs[ra][15:8]));
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_oe", 32'(mdio_oe), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        model_int = 1'b0;
        check_eq("rst_wr_dv", 32'(wr_pulses - wr0), 32'd0);
        check_eq("rst_rd_dv", 32'(rd_pulses - rd0), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op, ta;
        logic [4:0]  phy, ra;
        logic [15:0] wd;
        int          pre, sel;
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        rst    = 1'b1;
        mdc    = 1'b0;
        mdio_i = 1'b1;
        h_ra   = '0;
        h_wd   = '0;
        h_we   = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_mdio_oe", 32'(mdio_oe), 32'd0);
        check_eq("rst_mdio_o", 32'(mdio_o), 32'd0);
        check_eq("rst_pulses", 32'({wr_dv, rd_dv, frame_err}), 32'd0);
        check_eq("rst_wr_ra", 32'(wr_ra), 32'd0);
        check_eq("rst_wr_d", 32'(wr_d), 32'd0);
        check_eq("rst_h_rd", 32'(h_rd), 32'd0);
`ifdef MDIO_SLAVE_INT_EN
        check_eq("rst_mdint", 32'(mdint), 32'd0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
        host_check(5'h1F);

        // write then read back over the host port
        run_frame(32, 2'b01, PHY, 5'h04, 16'hA5C3, 2'b10, 0, 16'h0);
        host_check(5'h04);
        // MDIO read of a host-written register
        host_write(5'h02, 16'h1234);
        run_frame(32, 2'b10, PHY, 5'h02, 16'h0, 2'b10, 0, 16'h0);
        // other PHY, bad opcode, bad turnaround, short preamble
        run_frame(32, 2'b10, 5'd3, 5'h02, 16'h0, 2'b10, 0, 16'h0);
        run_frame(32, 2'b11, PHY, 5'h02, 16'h0, 2'b10, 0, 16'h0);
        run_frame(32, 2'b01, PHY, 5'h05, 16'hBEEF, 2'b11, 0, 16'h0);
        host_check(5'h05);
        run_frame(31, 2'b01, PHY, 5'h06, 16'h7777, 2'b10, 0, 16'h0);
        host_check(5'h06);
        // collisions
        host_write(5'h04, 16'hFFFF);
        run_frame(32, 2'b10, PHY, 5'h04, 16'h0, 2'b10, 1, 16'h0004);
        host_check(5'h04);
        run_frame(32, 2'b01, PHY, 5'h07, 16'h5A5A, 2'b10, 2, 16'h1111);
        host_check(5'h07);
        // host read of an address written in the same clk sees the old value
        h_ra = 5'h09;
        h_wd = 16'hC0DE;
        h_we = 1'b1;
        @(negedge clk);
        h_we = 1'b0;
        check_eq("h_rd_old", 32'(h_rd), 32'(model_regs[5'h09]));
        model_regs[5'h09] = 16'hC0DE;
        @(negedge clk);
        check_eq("h_rd_new", 32'(h_rd), 32'(model_regs[5'h09]));
        // interrupt set by a write, cleared by a status read
        run_frame(32, 2'b01, PHY, 5'h10, 16'h0F0F, 2'b10, 0, 16'h0);
        run_frame(32, 2'b10, PHY, INT_REG, 16'h0, 2'b10, 0, 16'h0);
        // reset in the middle of a read, then a clean frame pair
        host_write(5'h0C, 16'h9C3A);
        read_with_reset(5'h0C);
        host_check(5'h0C);
        run_frame(32, 2'b01, PHY, 5'h0C, 16'h3C96, 2'b10, 0, 16'h0);
        run_frame(32, 2'b10, PHY, 5'h0C, 16'h0, 2'b10, 0, 16'h0);

        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) op = 2'b11;
            else if (sel == 1) op = 2'b00;
            else op = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
            phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : PHY;
            ra  = 5'($urandom_range(0, 31));
            wd  = 16'($urandom);
            ta  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            pre = ($urandom_range(0, 7) == 0) ? 31 : 32;
            if ($urandom_range(0, 2) == 0) host_write(ra, 16'($urandom));
            run_frame(pre, op, phy, ra, wd, ta, 0, 16'h0);
            host_check(ra);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
